// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer around fpu_top: queues decoded FP ops and holds the head op stable until its result is written back.
// Latency: enqueue to in_valid two edges when idle, result to wb_valid one edge. Backpressure: ready drops when full or flushing.
module fpu_issue_ctrl #(
    parameter int FLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int OP_W  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [3:1][FLEN-1:0]      i_req_rs,
    input  logic [OP_W-1:0]           i_req_op,
    input  logic [2:0]                i_req_rm,
    input  logic [TAG_W-1:0]          i_req_rd,
    input  logic                      i_req_rd_int,
    output logic [3:1][FLEN-1:0]      o_fpu_rs,
    output logic [OP_W-1:0]           o_fpu_op,
    output logic [2:0]                o_fpu_rm_inst,
    output logic                      o_fpu_in_valid,
    input  logic                      i_fpu_in_ready,
    input  logic                      i_fpu_out_valid,
    output logic                      o_fpu_out_ready,
    input  logic [FLEN-1:0]           i_fpu_result,
    input  logic [4:0]                i_fpu_fflags,
    output logic                      o_wb_valid,
    input  logic                      i_wb_ready,
    output logic [FLEN-1:0]           o_wb_data,
    output logic [TAG_W-1:0]          o_wb_rd,
    output logic                      o_wb_rd_int,
    output logic [4:0]                o_wb_fflags,
    output logic [CNT_W-1:0]          o_count,
    output logic                      o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:1][FLEN-1:0] rs;
        logic [OP_W-1:0]      op;
        logic [2:0]           rm;
        logic [TAG_W-1:0]     rd;
        logic                 rd_int;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    entry_t             head;
    entry_t             req_ent;
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               kill_q, kill_d;
    logic               in_vld_q, in_vld_d;
    logic               out_rdy_q, out_rdy_d;
    logic               wb_vld_q, wb_vld_d;
    logic [FLEN-1:0]    wb_data_q, wb_data_d;
    logic [TAG_W-1:0]   wb_rd_q, wb_rd_d;
    logic               wb_rd_int_q, wb_rd_int_d;
    logic [4:0]         wb_fflags_q, wb_fflags_d;
    logic               req_rdy, push, pop, keep_head;

    // Ready depends only on registered count and flush; reset gating stays off the flop data path.
    assign req_rdy     = (cnt_q < CNT_W'(DEPTH)) && !i_flush;
    assign o_req_ready = req_rdy && i_rst_n;
    assign push        = i_req_valid && req_rdy;
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        req_ent.rs     = i_req_rs;
        req_ent.op     = i_req_op;
        req_ent.rm     = i_req_rm;
        req_ent.rd     = i_req_rd;
        req_ent.rd_int = i_req_rd_int;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = req_ent;
        end
    end

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_rd_int_d = wb_rd_int_q;
        wb_fflags_d = wb_fflags_q;
        pop         = 1'b0;
        keep_head   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0 && !i_flush) state_d = ISSUE;
            end
            ISSUE: begin
                if (i_fpu_in_ready) begin
                    state_d   = EXEC;
                    kill_d    = i_flush;
                    keep_head = 1'b1;
                end else if (i_flush) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                keep_head = !i_fpu_out_valid;
                if (i_fpu_out_valid) begin
                    if (kill_q || i_flush) begin
                        // Killed op: swallow the result and retire the head silently.
                        pop     = 1'b1;
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        wb_data_d   = i_fpu_result;
                        wb_fflags_d = i_fpu_fflags;
                        wb_rd_d     = head.rd;
                        wb_rd_int_d = head.rd_int;
                        state_d     = RESP;
                    end
                end else if (i_flush) begin
                    kill_d = 1'b1;
                end
            end
            RESP: begin
                if (i_flush) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else if (i_wb_ready) begin
                    pop     = 1'b1;
                    state_d = (cnt_q > CNT_W'(1)) ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_flush) begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = rd_ptr_q + PTR_W'(keep_head);
            cnt_d    = CNT_W'(keep_head);
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end

        in_vld_d  = (state_d == ISSUE);
        out_rdy_d = (state_d == EXEC);
        wb_vld_d  = (state_d == RESP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            in_vld_q    <= 1'b0;
            out_rdy_q   <= 1'b0;
            wb_vld_q    <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_rd_int_q <= 1'b0;
            wb_fflags_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            in_vld_q    <= in_vld_d;
            out_rdy_q   <= out_rdy_d;
            wb_vld_q    <= wb_vld_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_rd_int_q <= wb_rd_int_d;
            wb_fflags_q <= wb_fflags_d;
        end
    end

    assign o_fpu_rs        = (state_q != IDLE) ? head.rs : '0;
    assign o_fpu_op        = (state_q != IDLE) ? head.op : '0;
    assign o_fpu_rm_inst   = (state_q != IDLE) ? head.rm : '0;
    assign o_fpu_in_valid  = in_vld_q;
    assign o_fpu_out_ready = out_rdy_q;
    assign o_wb_valid      = wb_vld_q;
    assign o_wb_data       = wb_data_q;
    assign o_wb_rd         = wb_rd_q;
    assign o_wb_rd_int     = wb_rd_int_q;
    assign o_wb_fflags     = wb_fflags_q;
    assign o_count         = cnt_q;
    assign o_busy          = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; the bench itself plays fpu_top and the writeback consumer.
module tb_fpu_issue_ctrl;
    localparam int FLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int OP_W  = 8;
    localparam int CNT_W = 3;

    localparam logic [OP_W-1:0] OP_FADD = 8'h01;
    localparam logic [OP_W-1:0] OP_FDIV = 8'h04;
    localparam logic [OP_W-1:0] OP_FCVT = 8'h10;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  req_valid;
    logic                  req_ready;
    logic [3:1][FLEN-1:0]  req_rs;
    logic [OP_W-1:0]       req_op;
    logic [2:0]            req_rm;
    logic [TAG_W-1:0]      req_rd;
    logic                  req_rd_int;
    logic [3:1][FLEN-1:0]  fpu_rs;
    logic [OP_W-1:0]       fpu_op;
    logic [2:0]            fpu_rm;
    logic                  fpu_in_valid;
    logic                  fpu_in_ready;
    logic                  fpu_out_valid;
    logic                  fpu_out_ready;
    logic [FLEN-1:0]       fpu_result;
    logic [4:0]            fpu_fflags;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [FLEN-1:0]       wb_data;
    logic [TAG_W-1:0]      wb_rd;
    logic                  wb_rd_int;
    logic [4:0]            wb_fflags;
    logic [CNT_W-1:0]      count;
    logic                  busy;

    logic                  auto_mode;
    logic [FLEN-1:0]       man_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in FPU in streaming mode echoes rs1 so each writeback identifies its op.
    assign fpu_result = auto_mode ? fpu_rs[1] : man_result;

    fpu_issue_ctrl #(.FLEN(FLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_rs(req_rs), .i_req_op(req_op), .i_req_rm(req_rm),
        .i_req_rd(req_rd), .i_req_rd_int(req_rd_int),
        .o_fpu_rs(fpu_rs), .o_fpu_op(fpu_op), .o_fpu_rm_inst(fpu_rm),
        .o_fpu_in_valid(fpu_in_valid), .i_fpu_in_ready(fpu_in_ready),
        .i_fpu_out_valid(fpu_out_valid), .o_fpu_out_ready(fpu_out_ready),
        .i_fpu_result(fpu_result), .i_fpu_fflags(fpu_fflags),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_data(wb_data),
        .o_wb_rd(wb_rd), .o_wb_rd_int(wb_rd_int), .o_wb_fflags(wb_fflags),
        .o_count(count), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [FLEN-1:0] r1, input logic [FLEN-1:0] r2,
                           input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rd,
                           input logic rdi, input logic [2:0] rm);
        req_rs     = {32'h0, r2, r1};
        req_op     = op;
        req_rd     = rd;
        req_rd_int = rdi;
        req_rm     = rm;
    endtask

    initial begin
        logic acc;
        logic held;
        int   idx;
        int   wb_n;
        int   acc5;
        logic stall_seen;

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0;
        set_req('0, '0, '0, '0, 1'b0, 3'b000);
        fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; fpu_fflags = '0;
        wb_ready = 1'b0; auto_mode = 1'b0; man_result = '0;

        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_valid", fpu_in_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        // Single fadd 1.0 + 2.0
        set_req(32'h3F800000, 32'h40000000, OP_FADD, 5'd3, 1'b0, 3'b111);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("fadd_count1", count, 1);
        chk("fadd_in_valid_early", fpu_in_valid, 0);
        step();
        chk("fadd_in_valid", fpu_in_valid, 1);
        chk("fadd_op", fpu_op, OP_FADD);
        chk("fadd_rs", fpu_rs, {32'h0, 32'h40000000, 32'h3F800000});
        chk("fadd_rm", fpu_rm, 3'b111);
        fpu_in_ready = 1'b1;
        step();
        fpu_in_ready = 1'b0;
        chk("fadd_in_valid_drop", fpu_in_valid, 0);
        chk("fadd_out_ready", fpu_out_ready, 1);
        man_result = 32'h40400000; fpu_fflags = 5'd0; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0; man_result = 32'hDEADBEEF;
        chk("fadd_wb_valid", wb_valid, 1);
        chk("fadd_wb_data", wb_data, 32'h40400000);
        chk("fadd_wb_rd", wb_rd, 3);
        chk("fadd_wb_rd_int", wb_rd_int, 0);
        chk("fadd_wb_fflags", wb_fflags, 0);
        chk("fadd_out_ready_drop", fpu_out_ready, 0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("fadd_wb_done", wb_valid, 0);
        chk("fadd_count0", count, 0);
        chk("fadd_idle_busy", busy, 0);
        chk("fadd_idle_op", fpu_op, 0);

        // Five back-to-back requests into a 4-deep queue
        auto_mode = 1'b1; fpu_in_ready = 1'b1; fpu_out_valid = 1'b1; wb_ready = 1'b1;
        idx = 0; wb_n = 0; acc5 = -1; stall_seen = 1'b0;
        set_req(32'h10000000, 32'h0, OP_FADD, 5'd10, 1'b0, 3'b000);
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            acc = req_valid && req_ready;
            if (req_valid && !req_ready && idx == 4) stall_seen = 1'b1;
            if (wb_valid) begin
                if (wb_n < 5) begin
                    chk("b2b_data", wb_data, 32'h10000000 + wb_n);
                    chk("b2b_rd", wb_rd, 10 + wb_n);
                end
                wb_n++;
            end
            step();
            if (acc) begin
                if (idx == 4) acc5 = cyc;
                idx++;
                if (idx < 5) set_req(32'h10000000 + idx, 32'h0, OP_FADD, 5'(10 + idx), 1'b0, 3'b000);
                else req_valid = 1'b0;
            end
        end
        chk("b2b_wb_total", wb_n, 5);
        chk("b2b_fifth_accept_cycle", acc5, 5);
        chk("b2b_fifth_stalled", stall_seen, 1);
        chk("b2b_count_end", count, 0);
        auto_mode = 1'b0; fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; wb_ready = 1'b0;
        req_valid = 1'b0;

        // Slow fdiv with writeback backpressure
        set_req(32'h40400000, 32'h40000000, OP_FDIV, 5'd7, 1'b0, 3'b000);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("fdiv_in_valid", fpu_in_valid, 1);
        fpu_in_ready = 1'b1;
        step();
        fpu_in_ready = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (fpu_op !== OP_FDIV || fpu_out_ready !== 1'b1 || wb_valid !== 1'b0) held = 1'b0;
            step();
        end
        chk("fdiv_op_held_exec", held, 1);
        man_result = 32'h3FC00000; fpu_fflags = 5'b00001; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0; man_result = '0; fpu_fflags = '0;
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid !== 1'b1 || wb_data !== 32'h3FC00000 || wb_rd !== 5'd7 ||
                wb_fflags !== 5'b00001 || fpu_op !== OP_FDIV) held = 1'b0;
            step();
        end
        chk("fdiv_wb_stable", held, 1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("fdiv_wb_done", wb_valid, 0);
        chk("fdiv_count0", count, 0);

        // Flush while executing with two ops queued behind
        set_req(32'h1, 32'h0, OP_FADD, 5'd1, 1'b0, 3'b000);
        req_valid = 1'b1;
        step();
        set_req(32'h2, 32'h0, OP_FDIV, 5'd2, 1'b0, 3'b000);
        step();
        set_req(32'h3, 32'h0, OP_FDIV, 5'd3, 1'b0, 3'b000);
        fpu_in_ready = 1'b1;
        step();
        req_valid = 1'b0; fpu_in_ready = 1'b0;
        chk("fexec_count3", count, 3);
        chk("fexec_out_ready", fpu_out_ready, 1);
        flush = 1'b1; req_valid = 1'b1;
        #1;
        chk("fexec_ready_in_flush", req_ready, 0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk("fexec_count1", count, 1);
        chk("fexec_no_wb", wb_valid, 0);
        chk("fexec_op_held", fpu_op, OP_FADD);
        man_result = 32'h12345678; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        chk("fexec_count0", count, 0);
        chk("fexec_no_wb2", wb_valid, 0);
        chk("fexec_busy", busy, 0);
        step();
        chk("fexec_no_wb3", wb_valid, 0);
        chk("fexec_no_reissue", fpu_in_valid, 0);

        // Flush while presenting the op without handshake
        set_req(32'h4, 32'h0, OP_FADD, 5'd4, 1'b0, 3'b000);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("fiss_in_valid", fpu_in_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fiss_in_valid_drop", fpu_in_valid, 0);
        chk("fiss_count0", count, 0);
        chk("fiss_no_wb", wb_valid, 0);
        step();
        chk("fiss_busy", busy, 0);

        // Asynchronous reset in the middle of execution
        set_req(32'h5, 32'h6, OP_FADD, 5'd4, 1'b0, 3'b000);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        fpu_in_ready = 1'b1;
        step();
        fpu_in_ready = 1'b0;
        chk("arst_pre_out_ready", fpu_out_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_ready", fpu_out_ready, 0);
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_op", fpu_op, 0);
        chk("arst_rs", fpu_rs, 0);
        chk("arst_req_ready", req_ready, 0);
        #1;
        rst_n = 1'b1;
        step();
        chk("arst_idle_count", count, 0);
        set_req(32'h40400000, 32'h0, OP_FCVT, 5'd9, 1'b1, 3'b001);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("fcvt_in_valid", fpu_in_valid, 1);
        chk("fcvt_op", fpu_op, OP_FCVT);
        chk("fcvt_rm", fpu_rm, 3'b001);
        fpu_in_ready = 1'b1;
        step();
        fpu_in_ready = 1'b0;
        man_result = 32'h3; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        chk("fcvt_wb_valid", wb_valid, 1);
        chk("fcvt_wb_data", wb_data, 3);
        chk("fcvt_wb_rd", wb_rd, 9);
        chk("fcvt_wb_rd_int", wb_rd_int, 1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("fcvt_count0", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
